alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: MUL_CYCLES, 3, EXEC-state cycles for op 3'b011 (MUL), legal range 1..16.
REQ-002 SHALL have port: clk_i  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: reqN_valid_i  in  1 / reqN_ready_o  out  1 / reqN_op_i  in  3 / reqN_a_i  in  32 / reqN_b_i  in  32, for N = 0, 1 (requester handshake and payload).
REQ-005 SHALL have ports: alu_data1_o  out  32 / alu_data2_o  out  32 / alu_ctrl_o  out  3 (drive shared ALU); alu_result_i  in  32 (ALU output).
REQ-006 SHALL have ports: res_valid_o  out  1 / res_ready_i  in  1 / res_data_o  out  32 / res_id_o  out  1 (result handshake, winning requester index).
REQ-007 SHALL have port: busy_o  out  1, high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-009 In IDLE, reqN_ready_o SHALL be high combinationally only for the requester granted this cycle; never in EXEC/DONE.
REQ-010 Handshake = reqN_valid_i & reqN_ready_o; on it, op, a, b and N SHALL be latched and state SHALL go to EXEC next cycle.
REQ-011 Requesters SHALL hold valid and payload stable until handshake; the block SHALL not sample unaccepted payload.
REQ-012 alu_ctrl_o/alu_data1_o/alu_data2_o SHALL always equal latched op/a/b (zero after reset), independent of request inputs.
REQ-013 Non-MUL ops SHALL spend exactly 1 cycle in EXEC; MUL SHALL spend exactly MUL_CYCLES cycles, via down-counter loaded MUL_CYCLES-1 on handshake.
REQ-014 On the last EXEC cycle, alu_result_i SHALL be registered into res_data_o and state SHALL go to DONE.
REQ-015 Op 3'b110 (undefined) SHALL be accepted, take 1 EXEC cycle, and return res_data_o = 0.
REQ-016 In DONE, res_valid_o SHALL be 1 with res_data_o/res_id_o stable; on res_valid_o & res_ready_i state SHALL go to IDLE next cycle.
REQ-017 No new request SHALL be accepted in the DONE->IDLE handoff cycle; minimum issue interval 3 cycles (non-MUL, res_ready_i high).
REQ-018 Latency handshake -> res_valid_o SHALL be 2 cycles non-MUL, MUL_CYCLES+1 for MUL.
REQ-019 Both valid in IDLE SHALL grant exactly one requester per policy of REQ-026/027; loser keeps valid, ready low.

Reset
REQ-020 rst_i low SHALL immediately force state IDLE, abandoning any in-flight operation without output.
REQ-021 Reset values: res_valid_o 0, res_data_o 0, res_id_o 0, busy_o 0, alu_* 0, counter 0, last-grant register 1.
REQ-022 reqN_ready_o SHALL be 0 while rst_i low.
REQ-023 First grant after reset release SHALL be evaluated in the first clock edge with rst_i high.

Configuration
REQ-024 Macro ALU_ARB_RR_EN SHALL select the arbitration policy.
REQ-025 Last-grant register SHALL update to N on each handshake regardless of macro.
REQ-026 With ALU_ARB_RR_EN defined: round-robin; when both valid, grant the requester not in last-grant; single valid always granted.
REQ-027 Without ALU_ARB_RR_EN: fixed priority, requester 0 wins whenever req0_valid_i high.

Verification
REQ-028 Req0 ADD a=5 b=7 alone, res_ready_i=1 -> res_valid_o at handshake+2, res_data_o=12, res_id_o=0, busy_o high 2 cycles.
REQ-029 Req1 MUL a=6 b=7, MUL_CYCLES=3 -> alu_ctrl_o=3'b011 for 3 cycles, res_data_o=42 at handshake+4, res_id_o=1.
REQ-030 Both valid continuously with SUB, ALU_ARB_RR_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0 and req1_ready_o never high.
REQ-031 res_ready_i held low 5 cycles in DONE -> res_valid_o, res_data_o, res_id_o stable 5 cycles, both ready_o low, no new grant.
REQ-032 rst_i pulsed low in 2nd EXEC cycle of MUL -> busy_o=0, res_valid_o=0 immediately; no result emitted; next request completes normally.
REQ-033 Op 3'b110 a=1 b=1 -> accepted, res_data_o=0 at handshake+2.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared ALU.
// Each accepted request is latched, executed for one cycle (MUL_CYCLES cycles
// for MUL), and its result is held until the consumer takes it.
// Optional feature macro ALU_ARB_RR_EN: round-robin arbitration when defined,
// fixed priority (requester 0 first) when undefined.
module alu_arbiter #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic        res_id_o,
    output logic        busy_o
);

    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_UNDEF = 3'b110;
    // The counter holds the number of EXEC cycles still to come after this one.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_res;
    logic        r_id;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_hs0;
    logic        w_hs1;
    logic        w_hs;
    logic        w_exec_last;
    logic [2:0]  w_sel_op;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;

    // Grant selection; only offered in IDLE and never while reset is asserted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_IDLE && rst_i) begin
`ifdef ALU_ARB_RR_EN
            if (req0_valid_i && req1_valid_i) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = ~r_last_grant;
            end else begin
                w_gnt0 = req0_valid_i;
                w_gnt1 = req1_valid_i;
            end
`else
            w_gnt0 = req0_valid_i;
            w_gnt1 = req1_valid_i & ~req0_valid_i;
`endif
        end
    end

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;
    assign w_hs0        = req0_valid_i & w_gnt0;
    assign w_hs1        = req1_valid_i & w_gnt1;
    assign w_hs         = w_hs0 | w_hs1;
    assign w_exec_last  = (r_state == S_EXEC) && (r_cnt == 4'd0);

    // Payload of the requester being accepted; unaccepted payload is never used.
    always_comb begin
        w_sel_op = req0_op_i;
        w_sel_a  = req0_a_i;
        w_sel_b  = req0_b_i;
        if (w_hs1) begin
            w_sel_op = req1_op_i;
            w_sel_a  = req1_a_i;
            w_sel_b  = req1_b_i;
        end
    end

    // Next-state logic: accept -> execute -> hold result until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs)        w_state_nxt = S_EXEC;
            S_EXEC:  if (r_cnt == 4'd0) w_state_nxt = S_DONE;
            S_DONE:  if (res_ready_i) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the accepted operation and run the EXEC-cycle down-counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_op         <= 3'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
        end else if (w_hs) begin
            r_op         <= w_sel_op;
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_id         <= w_hs1;
            r_last_grant <= w_hs1;
            r_cnt        <= (w_sel_op == OP_MUL) ? MUL_LOAD : 4'd0;
        end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture the ALU result on the final EXEC cycle; the undefined op yields zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_res <= 32'd0;
        end else if (w_exec_last) begin
            r_res <= (r_op == OP_UNDEF) ? 32'd0 : alu_result_i;
        end
    end

    assign alu_ctrl_o  = r_op;
    assign alu_data1_o = r_a;
    assign alu_data2_o = r_b;
    assign res_data_o  = r_res;
    assign res_id_o    = r_id;
    assign res_valid_o = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);

endmodule
